// File: rtl/fetch_stage_if.sv
// Bundles the instruction-memory handshake and the fetch/decode/execute signals seen by the fetch stage.
// master is the fetch stage itself; slave is the memory/decode/execute side.
interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        StallF;
    logic        BranchTakenE;
    logic [31:0] BranchTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;

    modport master (
        output imem_req_o, imem_addr_o, InstrF, PCF, PCPlus4F, InstrValidF,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, StallF, BranchTakenE, BranchTargetE
    );

    modport slave (
        input  imem_req_o, imem_addr_o, InstrF, PCF, PCPlus4F, InstrValidF,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, StallF, BranchTakenE, BranchTargetE
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues req/gnt word reads, buffers in-order
// responses in a small FIFO and presents the head instruction to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   out_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_mem [DEPTH];

    logic          redirect;
    logic          pop;
    logic          issue;
    logic          rsp;
    logic          push;
    logic          req;
    logic [CW:0]   credit_used;
    logic [31:0]   target;

    // Credit counts every word that will land in the FIFO (buffered plus in flight),
    // including doomed ones, so the FIFO can never overflow.
    always_comb begin
        redirect    = bus.BranchTakenE;
        target      = {bus.BranchTargetE[31:2], 2'b00};
        pop         = (count != '0) & ~bus.StallF & ~redirect;
        credit_used = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
        req         = reset & ~redirect & (credit_used < DEPTH_W);
        issue       = req & bus.imem_gnt_i;
        rsp         = bus.imem_rvalid_i & (outstanding != '0);
        push        = rsp & (discard == '0) & ~redirect;
    end

    always_comb begin
        bus.imem_req_o  = req;
        bus.imem_addr_o = pc_q;
        bus.InstrValidF = (count != '0);
        bus.InstrF      = (count != '0) ? fifo_mem[rd_ptr] : 32'h0;
        bus.PCF         = out_pc;
        bus.PCPlus4F    = out_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            out_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(rsp);
            if (redirect) begin
                pc_q    <= target;
                out_pc  <= target;
                count   <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                // discard is a subset of outstanding, so every word still in flight is
                // marked doomed; this stays exact across back-to-back redirects.
                discard <= outstanding - CW'(rsp);
            end else begin
                if (issue) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (rsp && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    out_pc <= out_pc + 32'd4;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.imem_rdata_i;
        end
    end
endmodule
